// File: rtl/jimmy_pkg.sv
// Shared constants and types for the jimmy CPU and its port peripherals.
package jimmy_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PORT_N = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PORT_N-1:0] strobe_t;

endpackage

// File: rtl/jimmy_in_fifo_strobe_fall_detect.sv
// Falling-edge detector for a CPU port strobe; the previous level is registered.
module strobe_fall_detect (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic fall
);

    logic strobe_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe;
        end
    end

    // High during the cycle in which the strobe has just dropped.
    assign fall = strobe_q && !strobe;

endmodule

// File: rtl/jimmy_in_fifo.sv
// Buffered input-port responder: producer bytes are queued and presented on the
// CPU in_port; each falling edge of in_strobe retires the head entry.
module jimmy_in_fifo
    import jimmy_pkg::*;
#(
    parameter int unsigned      DEPTH       = 16,
    parameter int unsigned      WIDTH       = DATA_W,
    parameter logic [WIDTH-1:0] EMPTY_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [WIDTH-1:0]       in_port,
    input  logic                   in_strobe,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             pop_count,
    output logic                   underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_req;
    logic             push;
    logic             pop;

    strobe_fall_detect u_fall (
        .clk    (clk),
        .reset  (reset),
        .strobe (in_strobe),
        .fall   (pop_req)
    );

    assign empty    = (count == CNT_W'(0));
    assign full     = (count == CNT_W'(DEPTH));
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign pop      = pop_req && !empty;

    // Head is driven straight from storage so it holds steady under a read.
    assign in_port = empty ? EMPTY_VALUE : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_count <= '0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                pop_count <= pop_count + 8'(1);
            end
            if (pop_req && empty) begin
                underflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_jimmy_in_fifo.sv
// Self-checking bench for jimmy_in_fifo: constant vector table plus a queue
// scoreboard for the multi-cycle sequences.
module tb_jimmy_in_fifo;
    import jimmy_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] in_port;
    logic       in_strobe;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic [7:0] pop_count;
    logic       underflow;

    always #5 clk = ~clk;

    jimmy_in_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W), .EMPTY_VALUE(8'd0)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .in_port   (in_port),
        .in_strobe (in_strobe),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .pop_count (pop_count),
        .underflow (underflow)
    );

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       st;
        int         cnt;
        logic [7:0] inp;
        logic       und;
        logic [7:0] pc;
    } vec_t;

    vec_t tbl [12];

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mq [$];
    logic        m_sq;
    logic        m_under;
    logic [7:0]  m_pc;
    int unsigned rd_sum;
    int unsigned rd_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, advance the reference queue, sample 1ns after the edge.
    task automatic step(input logic wv, input logic [7:0] wd, input logic st);
        bit pr;
        bit push;
        bit was_empty;
        @(negedge clk);
        wr_valid  = wv;
        wr_data   = wd;
        in_strobe = st;
        was_empty = (mq.size() == 0);
        pr   = m_sq && !st;
        push = wv && (mq.size() != DEPTH);
        if (pr) begin
            if (!was_empty) begin
                chk("sb_head", 32'(in_port), 32'(mq[0]));
                rd_sum += 32'(mq[0]);
                rd_n++;
                void'(mq.pop_front());
                m_pc++;
            end else begin
                m_under = 1'b1;
            end
        end
        if (push) mq.push_back(wd);
        m_sq = st;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0);
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, "_count"}, 32'(count), 32'(n));
        chk({tag, "_in_port"}, 32'(in_port), (n == 0) ? 32'd0 : 32'(mq[0]));
        chk({tag, "_empty"}, 32'(empty), 32'(n == 0));
        chk({tag, "_full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'(n != DEPTH));
        chk({tag, "_underflow"}, 32'(underflow), 32'(m_under));
        chk({tag, "_pop_count"}, 32'(pop_count), 32'(m_pc));
    endtask

    task automatic do_reset(input logic st);
        @(negedge clk);
        reset     = 1'b1;
        wr_valid  = 1'b0;
        in_strobe = st;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mq.delete();
        m_sq    = 1'b0;
        m_under = 1'b0;
        m_pc    = 8'd0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'd5, 1'b0, 1, 8'd5, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 8'd3, 1'b0, 2, 8'd5, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 8'd4, 1'b0, 3, 8'd5, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 8'd0, 1'b1, 3, 8'd5, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 8'd0, 1'b1, 3, 8'd5, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 8'd0, 1'b0, 2, 8'd3, 1'b0, 8'd1};
        tbl[6]  = '{1'b0, 8'd0, 1'b1, 2, 8'd3, 1'b0, 8'd1};
        tbl[7]  = '{1'b0, 8'd0, 1'b1, 2, 8'd3, 1'b0, 8'd1};
        tbl[8]  = '{1'b0, 8'd0, 1'b0, 1, 8'd4, 1'b0, 8'd2};
        tbl[9]  = '{1'b0, 8'd0, 1'b1, 1, 8'd4, 1'b0, 8'd2};
        tbl[10] = '{1'b0, 8'd0, 1'b1, 1, 8'd4, 1'b0, 8'd2};
        tbl[11] = '{1'b0, 8'd0, 1'b0, 0, 8'd0, 1'b0, 8'd3};

        reset = 1'b0; wr_valid = 1'b0; wr_data = 8'd0; in_strobe = 1'b0;
        rd_sum = 0; rd_n = 0;
        do_reset(1'b0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_in_port", 32'(in_port), 32'd0);
        chk("rst_pop_count", 32'(pop_count), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);

        // Push 5,3,4 then three strobe pulses.
        foreach (tbl[i]) begin
            step(tbl[i].wv, tbl[i].wd, tbl[i].st);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_in_port", i), 32'(in_port), 32'(tbl[i].inp));
            chk($sformatf("tbl%0d_underflow", i), 32'(underflow), 32'(tbl[i].und));
            chk($sformatf("tbl%0d_pop_count", i), 32'(pop_count), 32'(tbl[i].pc));
            chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].cnt == 0));
        end

        // Fill to full, hold 17 while full, pop once and let 17 in.
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'd17, 1'b0);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        chk("full_count", 32'(count), 32'd16);
        chk("full_head", 32'(in_port), 32'd1);
        step(1'b1, 8'd17, 1'b1);
        step(1'b1, 8'd17, 1'b0);
        chk("full_pop_head", 32'(in_port), 32'd2);
        chk("full_pop_count", 32'(count), 32'd15);
        step(1'b1, 8'd17, 1'b0);
        chk("retry_count", 32'(count), 32'd16);
        step(1'b0, 8'd0, 1'b0);
        check_model("retry");
        for (int i = 0; i < 16; i++) begin
            pulse();
            check_model("drain");
        end

        // Empty read sets the sticky underflow.
        pulse();
        chk("uf_flag", 32'(underflow), 32'd1);
        chk("uf_pop_count", 32'(pop_count), 32'd20);
        step(1'b1, 8'd9, 1'b0);
        chk("uf_push_head", 32'(in_port), 32'd9);
        chk("uf_sticky", 32'(underflow), 32'd1);
        pulse();
        check_model("uf_drain");

        // Reset mid-operation with a coincident strobe fall.
        step(1'b1, 8'd1, 1'b0);
        step(1'b1, 8'd2, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        do_reset(1'b0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_pop_count", 32'(pop_count), 32'd0);
        chk("mid_rst_underflow", 32'(underflow), 32'd0);
        step(1'b0, 8'd0, 1'b0);
        check_model("post_rst");

        // Simultaneous push and pop at count=4, then at count=0.
        for (int i = 10; i < 14; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b0, 8'd0, 1'b1);
        step(1'b1, 8'd14, 1'b0);
        chk("pp4_count", 32'(count), 32'd4);
        chk("pp4_head", 32'(in_port), 32'd11);
        for (int i = 0; i < 4; i++) pulse();
        check_model("pp4_drain");
        step(1'b0, 8'd0, 1'b1);
        step(1'b1, 8'h55, 1'b0);
        chk("pp0_count", 32'(count), 32'd1);
        chk("pp0_head", 32'(in_port), 32'h55);
        chk("pp0_underflow", 32'(underflow), 32'd1);
        pulse();
        check_model("pp0_drain");

        // Averaging stream: ten samples read back, average 5.
        do_reset(1'b0);
        rd_sum = 0;
        rd_n   = 0;
        foreach (tbl[i]) begin end
        begin
            logic [7:0] samp [10];
            samp = '{8'd5, 8'd3, 8'd4, 8'd5, 8'd7, 8'd2, 8'd9, 8'd6, 8'd7, 8'd4};
            foreach (samp[i]) step(1'b1, samp[i], 1'b0);
        end
        for (int i = 0; i < 10; i++) pulse();
        pulse();
        chk("avg_reads", 32'(rd_n), 32'd10);
        chk("avg_value", 32'(rd_sum / 10), 32'd5);
        chk("avg_pop_count", 32'(pop_count), 32'd10);
        chk("avg_terminator", 32'(in_port), 32'd0);
        check_model("avg_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jimmy_in_fifo.md
# jimmy_in_fifo

Buffered input-port responder for the jimmy CPU: an external producer pushes bytes over a valid/ready handshake, and the block presents the oldest byte on the CPU input port. Each completed CPU read, marked by the falling edge of the CPU's in_strobe bit, retires that byte. It sits between a sample source and `jimmy.in_port_N`, replacing hand-driven bench stimulus with a real peripheral. When the FIFO is empty, the block presents a fixed terminator value so that zero-terminated programs end cleanly.

## Interface
- DEPTH, 16, FIFO entries; power of two, at least 2
- WIDTH, 8, data width; must equal the CPU port width
- EMPTY_VALUE, 8'd0, value driven on in_port while the FIFO is empty
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- wr_data  in  WIDTH  producer byte
- wr_valid  in  1  producer offers wr_data
- wr_ready  out  1  equals !full; a push occurs on wr_valid && wr_ready
- in_port  out  WIDTH  connects to the CPU in_port_N; head entry, or EMPTY_VALUE when empty
- in_strobe  in  1  the CPU in_strobe[N] bit, same clock domain
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH)+1  current occupancy
- pop_count  out  8  number of retired entries, wraps modulo 256
- underflow  out  1  sticky; set by a read attempted while empty

## Operation
- Storage: register array mem[DEPTH]; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- Push: when wr_valid && !full, write mem[wr_ptr] <= wr_data and increment wr_ptr.
- Read-complete detection: strobe_q <= in_strobe every cycle; pop_req = strobe_q && !in_strobe.
- Pop: when pop_req && !empty, increment rd_ptr and pop_count.
- Underflow: when pop_req && empty, set underflow; no pointer moves. The flag is cleared only by reset.
- count update: +1 on a push only, -1 on a pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - Non-empty, not full: both happen; count is unchanged.
  - Full: the pop happens, but the push is refused, because wr_ready reflects the pre-edge full state. The producer retries next cycle.
  - Empty: the push happens and the pop is counted as an underflow. The new byte stays at the head.
- in_port: combinational. It equals mem[rd_ptr] when !empty, else EMPTY_VALUE.
- A sustained high in_strobe retires nothing until it falls. Repeated strobe pulses retire one entry per falling edge.

## Timing
- Reset values: wr_ptr=0, rd_ptr=0, count=0, pop_count=0, underflow=0, strobe_q=0. As a result, empty=1, full=0, wr_ready=1, in_port=EMPTY_VALUE.
- Reset mid-operation discards all contents on that edge. A strobe falling edge coincident with reset is ignored.
- Push latency: a byte accepted at edge n appears on in_port after edge n (visible in cycle n+1) if the FIFO was empty.
- Pop latency: in_strobe falls during cycle k, and the pop is applied at the end of cycle k. The next entry is on in_port in cycle k+1.
- in_port is stable for the whole time in_strobe is high. The CPU samples during the strobe, so data never changes under a read.
- Throughput: one push and one pop per clock maximum.
- No combinational path from in_strobe to in_port or to wr_ready.

## Structure
- Shared package `jimmy_pkg`: DATA_W=8 and the port-count constant used by jimmy's strobe buses. EMPTY_VALUE stays a local parameter.
- One sub-module: `strobe_fall_detect` (clk, reset, strobe, fall). It is a registered falling-edge detector, reusable for the future out-port consumer.
- Pointer, count and flag logic stays in the top module.

## Test plan
- Reset, then push 5,3,4 with in_strobe idle -> count=3, in_port=5, full=0, wr_ready=1.
- Three strobe pulses (2 cycles high each) -> in_port steps 5 -> 3 -> 4 -> 0 (EMPTY_VALUE); pop_count=3; empty=1; underflow=0.
- Push 16 bytes 1..16, then hold wr_valid with 17 -> full=1, wr_ready=0, 17 not written. Strobe once -> head becomes 2; 17 accepted the following cycle; count=16.
- One strobe pulse with the FIFO empty -> underflow=1, pop_count unchanged. A later push of 9 gives in_port=9, and underflow stays 1 until reset.
- Push and pop on the same edge with count=4 -> count stays 4 and the head advances. Repeat with count=0 -> the pushed byte is retained and underflow=1.
- Connected to jimmy with the averaging program, feed 5,3,4,5,7,2,9,6,7,4 then empty -> ten pops, and out_port_2 reports average 5.
